// File: rtl/uart_tx_byte_queue_pkg.sv
// Shared definitions for the UART transmit byte queue: link byte width, idle byte, log2 helper.
package uart_tx_byte_queue_pkg;

    localparam int UART_BYTE_W = 8;
    localparam logic [UART_BYTE_W-1:0] TXQ_IDLE_BYTE = 8'h00;

    // Ceiling log2, usable in constant expressions for pointer/level widths.
    function automatic int log2c(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_byte_queue_if.sv
// Producer/UART-facing bundle of the transmit byte queue; master is the environment, slave is the queue.
interface uart_tx_byte_queue_if
    import uart_tx_byte_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = UART_BYTE_W
) ();

    localparam int LVL_W = log2c(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx_done;
    logic [DATA_W-1:0] tx_bits;
    logic              tx_is_data;
    logic [LVL_W-1:0]  level;
    logic [15:0]       sent_count;
    logic [7:0]        drop_count;

    modport master (
        output in_valid, in_data, tx_done,
        input  in_ready, tx_bits, tx_is_data, level, sent_count, drop_count
    );

    modport slave (
        input  in_valid, in_data, tx_done,
        output in_ready, tx_bits, tx_is_data, level, sent_count, drop_count
    );

endinterface

// File: rtl/uart_tx_byte_queue_sync_fifo.sv
// sync_fifo: registered FIFO storage with wrapping pointers and level count; reusable on the receive side.
module sync_fifo
    import uart_tx_byte_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = UART_BYTE_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [log2c(DEPTH):0]     level_o
);

    localparam int PTR_W = log2c(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              doPush, doPop;

    // Full is judged on the pre-pop level, so a simultaneous pop never admits a push.
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign rdata_o = mem_q[rdPtr_q];
    assign level_o = level_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_byte_queue.sv
// Queues command bytes for the UART and presents one per tx_done rising edge, else the idle byte.
// Optional statistics counters are built when TXQ_STATS_EN is defined.
module uart_tx_byte_queue
    import uart_tx_byte_queue_pkg::*;
#(
    parameter int                 DEPTH     = 8,
    parameter int                 DATA_W    = UART_BYTE_W,
    parameter logic [DATA_W-1:0]  IDLE_BYTE = TXQ_IDLE_BYTE
) (
    input logic                   clock,
    input logic                   reset,
    uart_tx_byte_queue_if.slave   bus
);

    localparam int LVL_W = log2c(DEPTH) + 1;

    logic              fifoFull, fifoEmpty;
    logic [DATA_W-1:0] fifoHead;
    logic [LVL_W-1:0]  fifoLevel;
    logic              txDonePrev_q;
    logic [DATA_W-1:0] txBits_q, txBits_d;
    logic              txIsData_q, txIsData_d;
    logic              advance, doPush, doPop;

    assign advance = bus.tx_done & ~txDonePrev_q;
    assign doPop   = advance & ~fifoEmpty;
    assign doPush  = bus.in_valid & ~fifoFull;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (doPush),
        .wdata_i (bus.in_data),
        .pop_i   (doPop),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifoLevel)
    );

    // No bypass: the head is sampled before this edge's push lands, so an empty queue yields IDLE_BYTE.
    always_comb begin
        txBits_d   = txBits_q;
        txIsData_d = txIsData_q;
        if (advance) begin
            if (fifoEmpty) begin
                txBits_d   = IDLE_BYTE;
                txIsData_d = 1'b0;
            end else begin
                txBits_d   = fifoHead;
                txIsData_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txDonePrev_q <= 1'b0;
            txBits_q     <= IDLE_BYTE;
            txIsData_q   <= 1'b0;
        end else begin
            txDonePrev_q <= bus.tx_done;
            txBits_q     <= txBits_d;
            txIsData_q   <= txIsData_d;
        end
    end

    assign bus.in_ready   = ~fifoFull;
    assign bus.tx_bits    = txBits_q;
    assign bus.tx_is_data = txIsData_q;
    assign bus.level      = fifoLevel;

`ifdef TXQ_STATS_EN
    logic [15:0] sentCount_q;
    logic [7:0]  dropCount_q;

    // Sent count wraps naturally; drop count sticks at its maximum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sentCount_q <= '0;
            dropCount_q <= '0;
        end else begin
            if (doPop) begin
                sentCount_q <= sentCount_q + 16'd1;
            end
            if (bus.in_valid && fifoFull && (dropCount_q != 8'hFF)) begin
                dropCount_q <= dropCount_q + 8'd1;
            end
        end
    end

    assign bus.sent_count = sentCount_q;
    assign bus.drop_count = dropCount_q;
`else
    assign bus.sent_count = 16'd0;
    assign bus.drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_uart_tx_byte_queue.sv
// Directed self-checking bench for uart_tx_byte_queue; expectations follow TXQ_STATS_EN when defined.
module tb_uart_tx_byte_queue;
    import uart_tx_byte_queue_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    uart_tx_byte_queue_if #(.DEPTH(8), .DATA_W(8)) bus ();

    uart_tx_byte_queue #(.DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       done;
        logic [7:0] expBits;
        logic       expIsData;
        logic [3:0] expLevel;
        logic       expReady;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic done);
        @(negedge clock);
        bus.in_valid = valid;
        bus.in_data  = data;
        bus.tx_done  = done;
        @(posedge clock);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [7:0] bits, input logic isData,
                              input logic [3:0] lvl, input logic ready);
        checkOutput({tag, ".tx_bits"}, 32'(bus.tx_bits), 32'(bits));
        checkOutput({tag, ".tx_is_data"}, 32'(bus.tx_is_data), 32'(isData));
        checkOutput({tag, ".level"}, 32'(bus.level), 32'(lvl));
        checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(ready));
    endtask

    task automatic checkStats(input string tag, input int sent, input int drop);
`ifdef TXQ_STATS_EN
        checkOutput({tag, ".sent_count"}, 32'(bus.sent_count), 32'(sent));
        checkOutput({tag, ".drop_count"}, 32'(bus.drop_count), 32'(drop));
`else
        checkOutput({tag, ".sent_count"}, 32'(bus.sent_count), 32'(sent * 0));
        checkOutput({tag, ".drop_count"}, 32'(bus.drop_count), 32'(drop * 0));
`endif
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.tx_done  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic addVec(input logic v, input logic [7:0] d, input logic dn, input logic [7:0] eb,
                          input logic ed, input logic [3:0] el, input logic er);
        vec_t x;
        x.valid = v; x.data = d; x.done = dn;
        x.expBits = eb; x.expIsData = ed; x.expLevel = el; x.expReady = er;
        vecs.push_back(x);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.tx_done  = 1'b0;

        // Idle pulses, then three bytes drained in order followed by an idle advance.
        addVec(0, 8'h00, 1, 8'h00, 0, 0, 1);
        addVec(0, 8'h00, 0, 8'h00, 0, 0, 1);
        addVec(0, 8'h00, 1, 8'h00, 0, 0, 1);
        addVec(0, 8'h00, 0, 8'h00, 0, 0, 1);
        addVec(0, 8'h00, 1, 8'h00, 0, 0, 1);
        addVec(0, 8'h00, 0, 8'h00, 0, 0, 1);
        addVec(1, 8'hA1, 0, 8'h00, 0, 1, 1);
        addVec(1, 8'hB2, 0, 8'h00, 0, 2, 1);
        addVec(1, 8'hC3, 0, 8'h00, 0, 3, 1);
        addVec(0, 8'h00, 1, 8'hA1, 1, 2, 1);
        addVec(0, 8'h00, 0, 8'hA1, 1, 2, 1);
        addVec(0, 8'h00, 1, 8'hB2, 1, 1, 1);
        addVec(0, 8'h00, 0, 8'hB2, 1, 1, 1);
        addVec(0, 8'h00, 1, 8'hC3, 1, 0, 1);
        addVec(0, 8'h00, 0, 8'hC3, 1, 0, 1);
        addVec(0, 8'h00, 1, 8'h00, 0, 0, 1);
        addVec(0, 8'h00, 0, 8'h00, 0, 0, 1);

        #2;
        checkState("reset", 8'h00, 1'b0, 4'd0, 1'b1);
        checkStats("reset", 0, 0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].done);
            checkState($sformatf("vec%0d", i), vecs[i].expBits, vecs[i].expIsData,
                       vecs[i].expLevel, vecs[i].expReady);
        end
        checkStats("table", 3, 0);

        // Fill past capacity: the ninth byte is refused.
        resetDut();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'hD0 + 8'(i), 1'b0);
        end
        checkState("full", 8'h00, 1'b0, 4'd8, 1'b0);
        checkStats("full", 0, 1);

        // Pop and push on the same edge while full: pop wins, push is refused, retried next cycle.
        applyStimulus(1'b1, 8'hE0, 1'b1);
        checkState("popFull", 8'hD0, 1'b1, 4'd7, 1'b1);
        checkStats("popFull", 1, 2);
        applyStimulus(1'b1, 8'hE0, 1'b0);
        checkState("refill", 8'hD0, 1'b1, 4'd8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] want;
            want = (i < 7) ? 8'hD1 + 8'(i) : 8'hE0;
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("drain%0d.tx_bits", i), 32'(bus.tx_bits), 32'(want));
            checkOutput($sformatf("drain%0d.level", i), 32'(bus.level), 32'(7 - i));
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        checkStats("drain", 9, 2);

        // tx_done held high for five cycles advances only once.
        resetDut();
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkState($sformatf("held%0d", i), 8'h11, 1'b1, 4'd1, 1'b1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkState("afterHeld", 8'h22, 1'b1, 4'd0, 1'b1);

        // Reset mid-stream clears everything immediately.
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h31 + 8'(i), 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkState("preReset", 8'h32, 1'b1, 4'd3, 1'b1);
        checkStats("preReset", 2, 0);
        #2;
        reset = 1'b1;
        #1;
        checkState("midReset", 8'h00, 1'b0, 4'd0, 1'b1);
        checkStats("midReset", 0, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Push/advance on the same edge ten times; first gives idle (no bypass), pointers wrap.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'h40 + 8'(i), 1'b1);
            if (i == 0) begin
                checkState("wrap0", 8'h00, 1'b0, 4'd1, 1'b1);
            end else begin
                checkState($sformatf("wrap%0d", i), 8'h40 + 8'(i - 1), 1'b1, 4'd1, 1'b1);
            end
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkState("wrapLast", 8'h49, 1'b1, 4'd0, 1'b1);
        checkStats("wrapLast", 10, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
